rc4_stream_gen: RTL and testbench
=================================

RC4_STREAM_GEN -- requirements
Module: rc4_stream_gen

Interface
REQ-001 Parameter MAX_KEY_BYTES, default 16, maximum supported key length in bytes (1..256).
REQ-002 Parameter DROP_N, default 0, keystream bytes discarded after KSA (RC4-dropN), 0..4095.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to (re)key and begin a stream.
REQ-006 key  input  8*MAX_KEY_BYTES  key bytes; byte n = key[8n+7:8n].
REQ-007 key_length  input  9  number of valid key bytes, sampled with start.
REQ-008 stop  input  1  abort the current stream, return to IDLE.
REQ-009 ks_ready  input  1  consumer accepts ks_data this cycle.
REQ-010 ks_data  output  8  keystream byte.
REQ-011 ks_valid  output  1  ks_data holds a valid byte.
REQ-012 busy  output  1  high in INIT, KSA, DROP.
REQ-013 err  output  1  one-cycle pulse on rejected start.
REQ-014 bytes_out  output  32  count of accepted keystream bytes since the last accepted start, wraps at 2^32.

Function
REQ-015 States: IDLE, INIT, KSA, DROP, STREAM; S-box is a 256x8 internal register array.
REQ-016 IDLE: start with 1 <= key_length <= MAX_KEY_BYTES latches key and key_length, clears bytes_out, -> INIT.
REQ-017 IDLE: start with key_length 0 or > MAX_KEY_BYTES -> err=1 for one cycle, remain IDLE, no other state change.
REQ-018 INIT: S[i]=i, one entry per cycle, i=0..255, 256 cycles, then j=0, -> KSA.
REQ-019 KSA: one iteration per cycle, i=0..255: j = j + S[i] + K[i mod key_length] (mod 256), swap S[i],S[j]; 256 cycles, then i=j=0, -> DROP if DROP_N>0 else STREAM.
REQ-020 PRGA step: i=i+1; j=j+S[i]; swap S[i],S[j]; byte = S[(S[i]+S[j]) mod 256] using post-swap values; all arithmetic mod 256.
REQ-021 DROP: one PRGA step per cycle, byte discarded, exactly DROP_N cycles, -> STREAM.
REQ-022 STREAM: ks_valid rises exactly 513+DROP_N cycles after the start edge; first byte is PRGA output number DROP_N+1.
REQ-023 Handshake: ks_data and ks_valid hold stable while ks_valid=1 and ks_ready=0; no PRGA step without acceptance.
REQ-024 Acceptance (ks_valid & ks_ready): next PRGA step executes same edge; next byte valid the following cycle, giving sustained one byte per cycle; bytes_out increments.
REQ-025 start in STREAM: behaves as in IDLE (valid restarts from INIT, ks_valid drops next cycle; invalid pulses err, stream continues unchanged).
REQ-026 start in INIT, KSA, DROP: ignored, no err.
REQ-027 stop in any non-IDLE state: -> IDLE next cycle, ks_valid=0, busy=0; stop and start in same cycle: stop wins.
REQ-028 Simultaneous acceptance and start in STREAM: byte counts as accepted (bytes_out incremented, then cleared by restart, net 0).
REQ-029 busy and ks_valid are never both 1.

Reset
REQ-030 rst_n low: immediately state IDLE, ks_valid=0, ks_data=0, busy=0, err=0, bytes_out=0, i=j=0; S-box contents need not be reset.
REQ-031 Reset mid-operation discards all progress; first cycle after release is IDLE and responds to start.

Verification
REQ-032 key[23:0]=24'h79654B ("Key"), key_length=3, DROP_N=0, ks_ready=1 -> bytes EB 9F 77 81 B7 34 CA 72 A7 19; ks_valid first high 513 cycles after start.
REQ-033 key[39:0]=40'h0504030201, key_length=5 -> first bytes B2 39 63 05 F0 3D C0 27.
REQ-034 Same key, ks_ready toggled randomly -> identical byte sequence; ks_data stable during every stall; bytes_out equals accepted count.
REQ-035 DROP_N=16, key as REQ-033 -> first byte equals 17th byte of DROP_N=0 run; ks_valid first high at 529 cycles.
REQ-036 key_length=0 and key_length=MAX_KEY_BYTES+1 -> err pulse, state IDLE; start during KSA -> ignored, sequence unchanged.
REQ-037 rst_n low during KSA, and stop during STREAM -> all outputs at reset values / IDLE; subsequent valid start reproduces REQ-032 vectors.

Source files
------------

// File: rtl/rc4_stream_gen.sv
// RC4 keystream generator: S-box init, key scheduling, optional drop-N, then a
// valid/ready byte stream with one PRGA step per accepted byte.
module rc4_stream_gen #(
  parameter int MAX_KEY_BYTES = 16,
  parameter int DROP_N        = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [8*MAX_KEY_BYTES-1:0] key,
  input  logic [8:0]                 key_length,
  input  logic                       stop,
  input  logic                       ks_ready,
  output logic [7:0]                 ks_data,
  output logic                       ks_valid,
  output logic                       busy,
  output logic                       err,
  output logic [31:0]                bytes_out
);
  typedef enum logic [2:0] {IDLE, INIT, KSA, DROP, STREAM} state_t;
  localparam logic [8:0]  MAXK     = 9'(MAX_KEY_BYTES);
  localparam logic [11:0] DROP_END = 12'(DROP_N - 1);

  state_t state, state_nxt;
  logic [7:0] sbox [256];
  logic [7:0] i, j, kidx;
  logic [11:0] drop_cnt;
  logic [8*MAX_KEY_BYTES-1:0] key_q;
  logic [8:0] len_q;

  logic key_ok, can_key, start_ok, start_bad, accept, step;
  logic [7:0] ki, kj, kj_idx, kbyte;
  logic [7:0] i1, pi, pj, pj_idx, t, pout;

  assign key_ok    = (key_length != 9'd0) && (key_length <= MAXK);
  assign can_key   = (state == IDLE) || (state == STREAM);
  assign start_ok  = can_key && start && !stop && key_ok;
  assign start_bad = can_key && start && !stop && !key_ok;
  assign accept    = ks_valid && ks_ready;
  // a new byte is produced whenever the output register is empty or being drained
  assign step      = (state == STREAM) && (!ks_valid || ks_ready) && !start_ok && !stop;
  assign busy      = (state == INIT) || (state == KSA) || (state == DROP);

  assign kbyte  = key_q[32'(kidx)*8 +: 8];
  assign ki     = sbox[i];
  assign kj_idx = j + ki + kbyte;
  assign kj     = sbox[kj_idx];

  assign i1     = i + 8'd1;
  assign pi     = sbox[i1];
  assign pj_idx = j + pi;
  assign pj     = sbox[pj_idx];
  assign t      = pi + pj;
  // output lookup must see the post-swap table
  assign pout   = (t == pj_idx) ? pi : (t == i1) ? pj : sbox[t];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_ok) state_nxt = INIT;
      INIT:   if (stop) state_nxt = IDLE;
              else if (i == 8'd255) state_nxt = KSA;
      KSA:    if (stop) state_nxt = IDLE;
              else if (i == 8'd255) state_nxt = (DROP_N > 0) ? DROP : STREAM;
      DROP:   if (stop) state_nxt = IDLE;
              else if (drop_cnt == DROP_END) state_nxt = STREAM;
      STREAM: if (stop) state_nxt = IDLE;
              else if (start_ok) state_nxt = INIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i         <= '0;
      j         <= '0;
      kidx      <= '0;
      drop_cnt  <= '0;
      key_q     <= '0;
      len_q     <= '0;
      ks_data   <= '0;
      ks_valid  <= 1'b0;
      err       <= 1'b0;
      bytes_out <= '0;
    end else begin
      err <= start_bad;
      if (start_ok)    bytes_out <= '0;
      else if (accept) bytes_out <= bytes_out + 32'd1;
      if (start_ok) begin
        key_q <= key;
        len_q <= key_length;
        i     <= '0;
        j     <= '0;
      end
      if (stop || start_ok) ks_valid <= 1'b0;
      case (state)
        INIT: begin
          i    <= i + 8'd1;
          j    <= '0;
          kidx <= '0;
        end
        KSA: begin
          i        <= i + 8'd1;
          j        <= (i == 8'd255) ? 8'd0 : kj_idx;
          kidx     <= (9'(kidx) + 9'd1 == len_q) ? 8'd0 : kidx + 8'd1;
          drop_cnt <= '0;
        end
        DROP: begin
          i        <= i1;
          j        <= pj_idx;
          drop_cnt <= drop_cnt + 12'd1;
        end
        STREAM: if (step) begin
          i        <= i1;
          j        <= pj_idx;
          ks_data  <= pout;
          ks_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // table contents are don't-care after reset; INIT rebuilds them on every start
  always_ff @(posedge clk) begin
    case (state)
      INIT: sbox[i] <= i;
      KSA: begin
        sbox[i]      <= kj;
        sbox[kj_idx] <= ki;
      end
      DROP: begin
        sbox[i1]     <= pj;
        sbox[pj_idx] <= pi;
      end
      STREAM: if (step) begin
        sbox[i1]     <= pj;
        sbox[pj_idx] <= pi;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rc4_stream_gen.sv
// Scoreboard bench: a plain-DROP instance and a drop-16 instance, directed RC4 vectors.
module tb_rc4_stream_gen;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  localparam logic [127:0] KEY1 = 128'h79654B;
  localparam logic [127:0] KEY2 = 128'h0504030201;

  logic [1:0]   st, rdy, v, b, e;
  logic         stop;
  logic [127:0] key;
  logic [8:0]   klen;
  logic [7:0]   d0, d1;
  logic [31:0]  bo0, bo1;

  rc4_stream_gen #(.MAX_KEY_BYTES(16), .DROP_N(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .key(key), .key_length(klen), .stop(stop),
    .ks_ready(rdy[0]), .ks_data(d0), .ks_valid(v[0]), .busy(b[0]), .err(e[0]), .bytes_out(bo0));
  rc4_stream_gen #(.MAX_KEY_BYTES(16), .DROP_N(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .key(key), .key_length(klen), .stop(stop),
    .ks_ready(rdy[1]), .ks_data(d1), .ks_valid(v[1]), .busy(b[1]), .err(e[1]), .bytes_out(bo1));

  int n_chk = 0, n_fail = 0;
  logic [7:0] q0[$], q1[$];
  int acc[2];
  bit stall_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int qs(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int u, input logic [7:0] x);
    if (u == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  // straightforward sequential RC4 used for longer expected runs
  task automatic model(input logic [127:0] k, input int len, input int skip, input int n, input int u);
    int s[256];
    int ii, jj, tmp;
    for (int x = 0; x < 256; x++) s[x] = x;
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + s[x] + int'(k[8*(x % len) +: 8])) % 256;
      tmp = s[x]; s[x] = s[jj]; s[jj] = tmp;
    end
    ii = 0; jj = 0;
    for (int c = 0; c < skip + n; c++) begin
      ii = (ii + 1) % 256;
      jj = (jj + s[ii]) % 256;
      tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
      if (c >= skip) push(u, 8'(s[(s[ii] + s[jj]) % 256]));
    end
  endtask

  // monitor: pops and compares on every accepted byte, checks stall stability
  logic [7:0] pd[2], dd, ex;
  logic       pv[2], pr[2];
  logic [31:0] bb;
  initial begin pv[0] = 0; pv[1] = 0; pr[0] = 0; pr[1] = 0; pd[0] = 0; pd[1] = 0; end
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      dd = (u == 0) ? d0 : d1;
      bb = (u == 0) ? bo0 : bo1;
      if (stall_en && pv[u] && !pr[u]) begin
        chk("stall_valid", 32'(v[u]), 32'd1);
        chk("stall_data", 32'(dd), 32'(pd[u]));
      end
      if (v[u] && rdy[u]) begin
        if (qs(u) == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_byte: dut%0d got %0h expected none", u, dd);
        end else begin
          if (u == 0) ex = q0.pop_front(); else ex = q1.pop_front();
          chk("ks_data", 32'(dd), 32'(ex));
        end
        chk("bytes_out_run", bb, 32'(acc[u]));
        acc[u]++;
      end
      pv[u] = v[u]; pr[u] = rdy[u]; pd[u] = dd;
    end
  end

  task automatic kick(input int u, input logic [127:0] k, input logic [8:0] len);
    @(negedge clk);
    key = k; klen = len; st[u] = 1'b1;
    @(posedge clk); #1;
    st[u] = 1'b0;
  endtask

  task automatic wait_valid(input int u, output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!v[u] && n < 1000);
    if (!v[u]) begin
      n_chk++; n_fail++;
      $display("FAIL valid_timeout: dut%0d got no ks_valid expected one within 1000", u);
    end
  endtask

  task automatic consume(input int u, input bit rnd, output int cyc);
    cyc = 0;
    rdy[u] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (qs(u) != 0 && cyc < 3000) begin
      @(posedge clk); #2; cyc++;
      if (qs(u) != 0) rdy[u] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    rdy[u] = 1'b0;
    if (qs(u) != 0) begin
      n_chk++; n_fail++;
      $display("FAIL consume_timeout: dut%0d got %0d left expected 0", u, qs(u));
    end
  endtask

  logic [7:0] vec1 [10];
  logic [7:0] vec2 [8];
  int n, cyc;

  task automatic push_vec1();
    for (int x = 0; x < 10; x++) push(0, vec1[x]);
  endtask

  initial begin
    vec1 = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    vec2 = '{8'hB2, 8'h39, 8'h63, 8'h05, 8'hF0, 8'h3D, 8'hC0, 8'h27};
    acc[0] = 0; acc[1] = 0;
    rst_n = 1'b0; st = '0; stop = 1'b0; rdy = '0; key = '0; klen = '0;
    #3;
    chk("rst_valid", 32'(v), 32'd0);
    chk("rst_busy", 32'(b), 32'd0);
    chk("rst_err", 32'(e), 32'd0);
    chk("rst_data", {16'd0, d1, d0}, 32'd0);
    chk("rst_bytes0", bo0, 32'd0);
    chk("rst_bytes1", bo1, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // "Key" vectors, sustained one byte per cycle
    kick(0, KEY1, 9'd3); acc[0] = 0;
    chk("busy_init", 32'(b[0]), 32'd1);
    wait_valid(0, n);
    chk("latency_key1", 32'(n), 32'd513);
    push_vec1();
    consume(0, 1'b0, cyc);
    chk("sustained", 32'(cyc), 32'd10);
    chk("bytes_out_10", bo0, 32'd10);

    // stop beats a simultaneous valid start
    @(negedge clk);
    stop = 1'b1; st[0] = 1'b1; key = KEY1; klen = 9'd3;
    @(posedge clk); #1;
    stop = 1'b0; st[0] = 1'b0;
    chk("stop_valid", 32'(v[0]), 32'd0);
    chk("stop_busy", 32'(b[0]), 32'd0);
    @(posedge clk); #1;
    chk("stop_stays_idle", 32'(b[0]), 32'd0);

    // rejected starts in IDLE
    kick(0, KEY1, 9'd0);
    chk("err_len0", 32'(e[0]), 32'd1);
    chk("err_len0_busy", 32'(b[0]), 32'd0);
    @(posedge clk); #1;
    chk("err_pulse_end", 32'(e[0]), 32'd0);
    kick(0, KEY1, 9'd17);
    chk("err_len17", 32'(e[0]), 32'd1);
    chk("err_len17_busy", 32'(b[0]), 32'd0);
    chk("err_keeps_bytes", bo0, 32'd10);

    // 0102030405: start during KSA ignored, invalid start mid-stream, random stalls
    kick(0, KEY2, 9'd5); acc[0] = 0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    key = KEY1; klen = 9'd3; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    chk("ksa_start_err", 32'(e[0]), 32'd0);
    chk("ksa_start_busy", 32'(b[0]), 32'd1);
    wait_valid(0, n);
    chk("latency_key2", 32'(301 + n), 32'd513);
    for (int x = 0; x < 4; x++) push(0, vec2[x]);
    consume(0, 1'b0, cyc);
    chk("bytes_out_4", bo0, 32'd4);
    kick(0, KEY2, 9'd17);
    chk("err_stream", 32'(e[0]), 32'd1);
    chk("err_stream_valid", 32'(v[0]), 32'd1);
    for (int x = 4; x < 8; x++) push(0, vec2[x]);
    consume(0, 1'b0, cyc);
    model(KEY2, 5, 8, 40, 0);
    stall_en = 1'b1;
    consume(0, 1'b1, cyc);
    stall_en = 1'b0;
    chk("bytes_out_48", bo0, 32'd48);

    // reset during KSA, then immediate restart
    kick(0, KEY1, 9'd3); acc[0] = 0;
    repeat (400) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(v[0]), 32'd0);
    chk("rst_mid_busy", 32'(b[0]), 32'd0);
    chk("rst_mid_bytes", bo0, 32'd0);
    chk("rst_mid_data", 32'(d0), 32'd0);
    acc[0] = 0;
    @(negedge clk);
    rst_n = 1'b1; key = KEY1; klen = 9'd3; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    wait_valid(0, n);
    chk("latency_after_rst", 32'(n), 32'd513);
    push_vec1();
    consume(0, 1'b0, cyc);

    // acceptance coinciding with restart nets bytes_out to zero
    model(KEY1, 3, 10, 1, 0);
    @(negedge clk);
    key = KEY1; klen = 9'd3; st[0] = 1'b1; rdy[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0; rdy[0] = 1'b0; acc[0] = 0;
    chk("restart_bytes", bo0, 32'd0);
    chk("restart_valid", 32'(v[0]), 32'd0);
    chk("restart_busy", 32'(b[0]), 32'd1);
    chk("restart_queue", 32'(q0.size()), 32'd0);
    @(negedge clk); stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    chk("stop_init_busy", 32'(b[0]), 32'd0);

    // drop-16 instance
    kick(1, KEY2, 9'd5); acc[1] = 0;
    wait_valid(1, n);
    chk("latency_drop16", 32'(n), 32'd529);
    model(KEY2, 5, 16, 8, 1);
    consume(1, 1'b0, cyc);
    chk("bytes_out_drop16", bo1, 32'd8);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (v[0] && b[0]) begin n_chk++; n_fail++; $display("FAIL busy_and_valid0: got both expected exclusive"); end
      if (v[1] && b[1]) begin n_chk++; n_fail++; $display("FAIL busy_and_valid1: got both expected exclusive"); end
    end
  end
endmodule
